// File: rtl/inst_load_pkg.sv
// Shared types and constants for the instruction load sequencer.
// The INST_LOAD_CHECKSUM_EN build option enables the CHK state and the checksum error.
package inst_load_pkg;

  localparam int cXLEN = 32;
  localparam logic [cXLEN-1:0] cEndMarker = 32'hDEADBEAF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHK,
    SETTLE,
    RUN,
    DONE,
    ERR
  } tLoadState;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_OVF   = 2'd1,
    ERR_EMPTY = 2'd2,
    ERR_CSUM  = 2'd3
  } tLoadErr;

endpackage

// File: rtl/inst_load_wr_stage.sv
// Registered instruction-memory write stage with word counter and
// byte-address generation; one cycle from accept to write strobe.
module inst_load_wr_stage
  import inst_load_pkg::*;
#(
  parameter int cCntW = 11,
  parameter logic [cXLEN-1:0] cBaseAddr = '0
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iClr,
  input  logic             iWr,
  input  logic [cXLEN-1:0] iData,
  output logic             oWen,
  output logic [cXLEN-1:0] oAddr,
  output logic [cXLEN-1:0] oData,
  output logic [cCntW-1:0] oCnt
);

  logic             wen_q;
  logic [cXLEN-1:0] addr_q, addr_d;
  logic [cXLEN-1:0] data_q, data_d;
  logic [cCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (iWr) begin
      addr_d = cBaseAddr + (cXLEN'(cnt_q) << 2);
      data_d = iData;
      cnt_d  = cnt_q + 1'b1;
    end
    if (iClr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      wen_q  <= iWr;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign oWen  = wen_q;
  assign oAddr = addr_q;
  assign oData = data_q;
  assign oCnt  = cnt_q;

endmodule

// File: rtl/inst_load_ctrl.sv
// Boot/load sequencer: streams words into instruction memory, then starts the core.
// Define INST_LOAD_CHECKSUM_EN to require a trailing wrap-around sum word.
module inst_load_ctrl
  import inst_load_pkg::*;
#(
  parameter int cMemDepth = 1024,
  parameter int cStartDelay = 2,
  parameter logic [cXLEN-1:0] cBaseAddr = '0,
  parameter logic [cXLEN-1:0] cMarker = cEndMarker,
  localparam int cCntW = $clog2(cMemDepth) + 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iInstVld,
  input  logic [cXLEN-1:0] iInst,
  output logic             oInstRdy,
  output logic             oMemWen,
  output logic [cXLEN-1:0] oMemAddr,
  output logic [cXLEN-1:0] oMemData,
  output logic             oStart,
  input  logic             iHalt,
  input  logic             iRestart,
  output logic             oRunning,
  output logic [cCntW-1:0] oWordCnt,
  output logic [1:0]       oErr
);

  localparam int cDlyW = $clog2(cStartDelay + 2);

  tLoadState        state_q, state_d;
  tLoadErr          err_q, err_d;
  logic [cDlyW-1:0] dly_q, dly_d;
  logic             acc, is_mark, full, wr, clr, start;

`ifdef INST_LOAD_CHECKSUM_EN
  logic [cXLEN-1:0] sum_q;
  assign oInstRdy = (state_q == IDLE) || (state_q == LOAD) ||
                    (state_q == CHK);
`else
  assign oInstRdy = (state_q == IDLE) || (state_q == LOAD);
`endif

  assign acc     = iInstVld && oInstRdy;
  assign is_mark = (iInst == cMarker);
  assign full    = (oWordCnt == cCntW'(cMemDepth));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    dly_d   = dly_q;
    wr      = 1'b0;
    clr     = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        if (acc) begin
          state_d = LOAD;
          if (is_mark) begin
            if (oWordCnt == '0) begin
              state_d = ERR;
              err_d   = ERR_EMPTY;
            end else begin
`ifdef INST_LOAD_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = SETTLE;
`endif
            end
          end else if (full) begin
            state_d = ERR;
            err_d   = ERR_OVF;
          end else begin
            wr = 1'b1;
          end
        end
      end
`ifdef INST_LOAD_CHECKSUM_EN
      CHK: begin
        if (acc) begin
          if (iInst == sum_q) begin
            state_d = SETTLE;
          end else begin
            state_d = ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
`endif
      SETTLE: begin
        if (dly_q == cDlyW'(cStartDelay)) begin
          start   = 1'b1;
          dly_d   = '0;
          state_d = RUN;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      RUN: begin
        if (iHalt) state_d = DONE;
      end
      DONE: begin
        if (iRestart) begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      end
      ERR: begin
        if (iRestart) begin
          state_d = IDLE;
          err_d   = ERR_NONE;
          clr     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      dly_q   <= dly_d;
    end
  end

`ifdef INST_LOAD_CHECKSUM_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (wr) begin
      sum_q <= sum_q + iInst;
    end
  end
`endif

  inst_load_wr_stage #(
    .cCntW    (cCntW),
    .cBaseAddr(cBaseAddr)
  ) u_wr (
    .iClk (iClk),
    .iRst (iRst),
    .iClr (clr),
    .iWr  (wr),
    .iData(iInst),
    .oWen (oMemWen),
    .oAddr(oMemAddr),
    .oData(oMemData),
    .oCnt (oWordCnt)
  );

  assign oStart   = start;
  assign oRunning = (state_q == RUN);
  assign oErr     = err_q;

endmodule

// File: tb/tb_inst_load_ctrl.sv
// Scoreboard bench for inst_load_ctrl: program-level model predicts
// writes, start timing and final status for directed and random loads.
module tb_inst_load_ctrl;

  localparam int DEPTH = 4;
  localparam int DLY   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] MARK = 32'hDEADBEAF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [31:0]   inst = '0;
  logic          halt = 1'b0;
  logic          restart = 1'b0;
  logic          rdy, wen, start, running;
  logic [31:0]   addr, data;
  logic [CW-1:0] cnt;
  logic [1:0]    err;

  inst_load_ctrl #(
    .cMemDepth  (DEPTH),
    .cStartDelay(DLY)
  ) dut (
    .iClk    (clk),
    .iRst    (rst),
    .iInstVld(vld),
    .iInst   (inst),
    .oInstRdy(rdy),
    .oMemWen (wen),
    .oMemAddr(addr),
    .oMemData(data),
    .oStart  (start),
    .iHalt   (halt),
    .iRestart(restart),
    .oRunning(running),
    .oWordCnt(cnt),
    .oErr    (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];
  int  sq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  wr_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (wen) begin
        if (wq.size() == 0) begin
          chk("unexpected_wen", 32'd1, 32'd0);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", addr, e.a);
          chk("wr_data", data, e.d);
        end
      end
      if (start) begin
        if (sq.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else chk("start_cycle", cyc, sq.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [31:0] w);
    chk("rdy_before_word", {31'd0, rdy}, 32'd1);
    vld  = 1'b1;
    inst = w;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == MARK) w = w ^ 32'h1;
    return w;
  endfunction

  // Program-level model: p holds the non-marker words of one load.
  task automatic load(input logic [31:0] p[$], input bit gaps,
                      input bit bad_sum, output int exp_err);
    int n, nw, nsend;
    logic [31:0] s;
    n  = p.size();
    nw = (n > DEPTH) ? DEPTH : n;
    s  = '0;
    if (n == 0) exp_err = 2;
    else if (n > DEPTH) exp_err = 1;
    else exp_err = 0;
`ifdef INST_LOAD_CHECKSUM_EN
    if (exp_err == 0 && bad_sum) exp_err = 3;
`endif
    for (int i = 0; i < nw; i++) begin
      wq.push_back('{a: 32'(4 * i), d: p[i]});
      s += p[i];
    end
    nsend = (n > DEPTH) ? DEPTH + 1 : n;
    for (int i = 0; i < nsend; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      put(p[i]);
    end
    if (n <= DEPTH) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
`ifdef INST_LOAD_CHECKSUM_EN
      put(MARK);
      if (n > 0) begin
        if (gaps && $urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        if (exp_err == 0) sq.push_back(cyc + 1 + DLY);
        put(bad_sum ? s + 32'd1 : s);
      end
`else
      if (exp_err == 0) sq.push_back(cyc + 1 + DLY);
      put(MARK);
`endif
    end
    idle(DLY + 4);
    chk("err_after_load", {30'd0, err}, 32'(exp_err));
    chk("cnt_after_load", 32'(cnt), 32'(nw));
    chk("rdy_after_load", {31'd0, rdy}, 32'd0);
    chk("running_after_load", {31'd0, running}, {31'd0, exp_err == 0});
    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("starts_drained", 32'(sq.size()), 32'd0);
  endtask

  task automatic finish_run(input int exp_err);
    if (exp_err == 0) begin
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("restart_ignored_in_run", {31'd0, running}, 32'd1);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      chk("running_after_halt", {31'd0, running}, 32'd0);
      chk("rdy_in_done", {31'd0, rdy}, 32'd0);
    end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("err_after_restart", {30'd0, err}, 32'd0);
    chk("cnt_after_restart", 32'(cnt), 32'd0);
    chk("rdy_after_restart", {31'd0, rdy}, 32'd1);
  endtask

  initial begin
    logic [31:0] q[$];
    int ee;

    repeat (3) @(negedge clk);
    chk("reset_rdy", {31'd0, rdy}, 32'd1);
    chk("reset_wen", {31'd0, wen}, 32'd0);
    chk("reset_cnt", 32'(cnt), 32'd0);
    chk("reset_err", {30'd0, err}, 32'd0);
    chk("reset_running", {31'd0, running}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_ignored_idle", {31'd0, rdy}, 32'd1);

    q = '{32'h00000013, 32'h00100093, 32'h00208113};
    load(q, 1'b0, 1'b0, ee);
    finish_run(ee);

    q = {};
    load(q, 1'b0, 1'b0, ee);
    finish_run(ee);

    q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    load(q, 1'b0, 1'b0, ee);
    finish_run(ee);

    wq.push_back('{a: 32'h0, d: 32'hA0});
    wq.push_back('{a: 32'h4, d: 32'hA1});
    put(32'hA0);
    put(32'hA1);
    idle(2);
    rst = 1'b1;
    #1;
    chk("midrst_wen", {31'd0, wen}, 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    chk("midrst_rdy", {31'd0, rdy}, 32'd1);
    chk("midrst_start", {31'd0, start}, 32'd0);
    chk("midrst_err", {30'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_writes_done", 32'(wq.size()), 32'd0);
    q = '{32'hB0};
    load(q, 1'b0, 1'b0, ee);
    finish_run(ee);

`ifdef INST_LOAD_CHECKSUM_EN
    q = '{32'h1, 32'h2};
    load(q, 1'b0, 1'b0, ee);
    finish_run(ee);
    q = '{32'h1, 32'h2};
    load(q, 1'b0, 1'b1, ee);
    finish_run(ee);
`endif

    for (int it = 0; it < 25; it++) begin
      q = {};
      for (int k = 0; k < $urandom_range(0, DEPTH + 2); k++)
        q.push_back(rnd_word());
      load(q, 1'b1, 1'($urandom_range(0, 1)), ee);
      finish_run(ee);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/inst_load_ctrl.md
Name: inst_load_ctrl

Overview:
- Boot/load sequencer between an instruction source (bench file reader or host link) and the core's instruction-memory write port and start input.
- Accepts a stream of 32-bit words over a valid/ready handshake and writes them to consecutive instruction-memory addresses.
- Detects the end-of-program marker, waits for the write pipeline to drain, then pulses start to the core.
- Tracks run/halt status and reports load errors.

Parameters:
- cXLEN, 32, data/address width.
- cMemDepth, 1024, instruction memory depth in words; max program length.
- cEndMarker, 32'hDEADBEAF, end-of-program word; never written to memory.
- cStartDelay, 2, idle cycles between the last memory write and the oStart pulse.
- cBaseAddr, 0, byte address of the first instruction.

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset; asynchronous, active-high.
- iInstVld  in  1  source word valid.
- iInst  in  cXLEN  source word.
- oInstRdy  out  1  controller can accept a word.
- oMemWen  out  1  instruction-memory write enable.
- oMemAddr  out  cXLEN  byte write address.
- oMemData  out  cXLEN  write data.
- oStart  out  1  one-cycle core start pulse.
- iHalt  in  1  core reports halt; sampled only in RUN.
- iRestart  in  1  return to IDLE from DONE or ERR.
- oRunning  out  1  high while in RUN.
- oWordCnt  out  $clog2(cMemDepth)+1  words written.
- oErr  out  2  0 none, 1 overflow, 2 empty program, 3 checksum mismatch.

Behaviour:
- Reset (async assert, deassert sampled on iClk):
  - State = IDLE.
  - All outputs 0, except oInstRdy = 1.
  - Word counter and delay counter cleared.
  - Reset asserted mid-LOAD or mid-RUN aborts immediately; no oStart is issued.
- Handshake: a word is accepted on a cycle where iInstVld && oInstRdy. oInstRdy = 1 only in IDLE and LOAD.
- IDLE: an accepted word is handled exactly as in LOAD, and the state becomes LOAD.
- LOAD, accepted word != cEndMarker:
  - Registered write, 1-cycle latency: next cycle oMemWen = 1, oMemData = word, oMemAddr = cBaseAddr + 4*oWordCnt.
  - oWordCnt increments in that same cycle.
- LOAD, accepted word == cEndMarker:
  - If oWordCnt == 0: go to ERR with oErr = 2.
  - Otherwise: go to SETTLE (or CHK when the optional feature is compiled in).
- Overflow: a non-marker word accepted when oWordCnt == cMemDepth is dropped (no write), and the state goes to ERR with oErr = 1.
- SETTLE:
  - oInstRdy = 0; delay counter counts cStartDelay cycles after the final write.
  - Then oStart = 1 for exactly one cycle and the state goes to RUN.
  - cStartDelay = 0 means oStart appears in the cycle after the final oMemWen.
- RUN: oRunning = 1. iHalt = 1 moves to DONE; oRunning falls the next cycle.
- DONE: iRestart moves to IDLE and clears oWordCnt. Memory contents are untouched.
- ERR:
  - oErr is sticky; oInstRdy = 0; oStart is never asserted.
  - iRestart moves to IDLE and clears oErr and oWordCnt.
- iRestart is ignored in IDLE, LOAD, SETTLE and RUN.
- iHalt is ignored outside RUN.
- oStart pulses exactly once per successful load.

Optional Feature:
- Macro INST_LOAD_CHECKSUM_EN.
- With the macro:
  - A 32-bit wrap-around sum of all written words is accumulated.
  - After the marker, the state goes to CHK with oInstRdy = 1.
  - The next accepted word is the expected sum and is not written.
  - Match goes to SETTLE; mismatch goes to ERR with oErr = 3.
- Without the macro: CHK, the accumulator and oErr = 3 do not exist; marker goes directly to SETTLE.

Decomposition:
- Shared package:
  - tLoadState enum: IDLE, LOAD, CHK, SETTLE, RUN, DONE, ERR.
  - tLoadErr enum.
  - cEndMarker default and cXLEN, reusing the existing core package constant.
- One sub-module, inst_load_wr_stage: the registered memory-write stage (wen/addr/data register plus address generation), kept separate so the write latency is testable in isolation.

Test Plan:
- Words 0x00000013, 0x00100093, 0x00208113, then 0xDEADBEAF, vld held high -> three writes at addresses 0x0, 0x4, 0x8; oWordCnt = 3; oStart single pulse 2 cycles after the last oMemWen; oRunning = 1.
- First word 0xDEADBEAF -> oErr = 2; no oMemWen, no oStart; iRestart -> IDLE, oErr = 0.
- cMemDepth = 4, five non-marker words -> four writes, fifth word dropped, oErr = 1, oInstRdy = 0.
- iRst asserted two cycles after the second word, then released -> all outputs 0, oWordCnt = 0; reloading 1 word + marker produces a clean start.
- In RUN, drive iHalt for one cycle -> DONE, oRunning low; iRestart -> IDLE; a second load starts again at address 0x0.
- INST_LOAD_CHECKSUM_EN: words 0x1, 0x2, marker, 0x3 -> oStart; same stream with checksum 0x4 -> oErr = 3, no oStart.
